// File: rtl/data_sram_if.sv
// ---------------------------------------------------------------------------
// data_sram_if
//   Bundles the CPU data_sram port. The core drives en/we/addr/wdata and the
//   responder returns rdata one cycle after an access.
//   Signals:
//     data_sram_en     access strobe (read and/or write this cycle)
//     data_sram_we     byte write enables, bit i -> wdata[8i+7:8i]
//     data_sram_addr   byte address (bits [1:0] ignored by the responder)
//     data_sram_wdata  store data
//     data_sram_rdata  load data, valid the cycle after en=1
//   Modports:
//     master  core side
//     slave   responder side
// ---------------------------------------------------------------------------
interface data_sram_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_we,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_we,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_resp.sv
// ---------------------------------------------------------------------------
// data_sram_resp
//   Responder end of the CPU data_sram port. Loads and stores are served with
//   a fixed one-cycle read latency. The low address space is backed by a
//   word-addressed RAM. A small MMIO window holds a free-running timer, a
//   compare register, a control/status register and an LED register. The
//   timer compare match raises ext_int_o towards the core.
//
//   Parameters:
//     ADDR_W   RAM depth is 2**ADDR_W 32-bit words
//     MMIO_HI  addr[31:16] value selecting the MMIO window
//     LED_W    width of the LED register
//   Ports:
//     clk        single clock, all state on the rising edge
//     rst_n      asynchronous active-low reset
//     bus        data_sram_if.slave (en/we/addr/wdata in, rdata out)
//     ext_int_o  timer interrupt request (level)
//     led_o      LED register contents
//
//   MMIO map (addr[3:2], addr[15:4] ignored inside the window):
//     0 TIMER    1 TIMECMP    2 TCTRL {PEND,IE,EN}    3 LED
// ---------------------------------------------------------------------------
module data_sram_resp #(
  parameter int          ADDR_W  = 14,
  parameter logic [15:0] MMIO_HI = 16'hBFAF,
  parameter int          LED_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  data_sram_if.slave       bus,
  output logic             ext_int_o,
  output logic [LED_W-1:0] led_o
);

  localparam int          DEPTH   = 2 ** ADDR_W;
  localparam logic [1:0]  OFF_TIMER = 2'd0;
  localparam logic [1:0]  OFF_TCMP  = 2'd1;
  localparam logic [1:0]  OFF_TCTRL = 2'd2;
  localparam logic [1:0]  OFF_LED   = 2'd3;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic              acc_en;
  logic              is_mmio;
  logic [1:0]        mmio_off;
  logic [ADDR_W-1:0] ram_idx;
  logic              mmio_wr;
  logic              ram_acc;

  assign acc_en   = bus.data_sram_en;
  assign is_mmio  = (bus.data_sram_addr[31:16] == MMIO_HI);
  assign mmio_off = bus.data_sram_addr[3:2];
  // Upper address bits above the RAM index are ignored, so the RAM aliases.
  assign ram_idx  = bus.data_sram_addr[ADDR_W+1:2];
  // Partial-width stores to MMIO registers are dropped entirely.
  assign mmio_wr  = acc_en && is_mmio && (bus.data_sram_we == 4'hF);
  // Accesses seen while reset is held must not touch the RAM.
  assign ram_acc  = rst_n && acc_en && !is_mmio;

  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, bus.data_sram_addr[1:0]};

  // -------------------------------------------------------------------------
  // RAM: read-first, registered read, per-byte write enables, no reset.
  // -------------------------------------------------------------------------
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] ram_rd_q;

  always_ff @(posedge clk) begin
    if (ram_acc) begin
      ram_rd_q <= mem[ram_idx];
      for (int b = 0; b < 4; b++) begin
        if (bus.data_sram_we[b]) begin
          mem[ram_idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // MMIO registers
  // -------------------------------------------------------------------------
  logic [31:0]      timer_q,   timer_d;
  logic [31:0]      timecmp_q, timecmp_d;
  logic             tc_en_q,   tc_en_d;
  logic             tc_ie_q,   tc_ie_d;
  logic             pend_q,    pend_d;
  logic             ext_int_q, ext_int_d;
  logic [LED_W-1:0] led_q,     led_d;

  // Read-response bookkeeping. valid_q keeps rdata at zero from reset until
  // the first access; sel_mmio_q picks between the RAM and MMIO capture.
  logic             valid_q,    valid_d;
  logic             sel_mmio_q, sel_mmio_d;
  logic [31:0]      mmio_rd_q,  mmio_rd_d;

  logic             match;
  logic [31:0]      mmio_rd_val;

  // Compare uses the pre-increment timer value.
  assign match = tc_en_q && (timer_q == timecmp_q);

  always_comb begin
    mmio_rd_val = 32'd0;
    case (mmio_off)
      OFF_TIMER: mmio_rd_val = timer_q;
      OFF_TCMP:  mmio_rd_val = timecmp_q;
      OFF_TCTRL: mmio_rd_val = {29'd0, pend_q, tc_ie_q, tc_en_q};
      OFF_LED:   mmio_rd_val = 32'(led_q);
      default:   mmio_rd_val = 32'd0;
    endcase
  end

  always_comb begin
    timer_d    = timer_q;
    timecmp_d  = timecmp_q;
    tc_en_d    = tc_en_q;
    tc_ie_d    = tc_ie_q;
    pend_d     = pend_q;
    led_d      = led_q;
    valid_d    = valid_q;
    sel_mmio_d = sel_mmio_q;
    mmio_rd_d  = mmio_rd_q;

    if (tc_en_q) begin
      timer_d = timer_q + 32'd1;
    end

    if (mmio_wr) begin
      case (mmio_off)
        // A software write overrides the increment in the same cycle.
        OFF_TIMER: timer_d   = bus.data_sram_wdata;
        OFF_TCMP:  timecmp_d = bus.data_sram_wdata;
        OFF_TCTRL: begin
          tc_en_d = bus.data_sram_wdata[0];
          tc_ie_d = bus.data_sram_wdata[1];
          if (bus.data_sram_wdata[2]) begin
            pend_d = 1'b0;
          end
        end
        OFF_LED:   led_d = bus.data_sram_wdata[LED_W-1:0];
        default:   ;
      endcase
    end

    // Evaluated after the write-1-clear so a same-cycle match keeps PEND set.
    if (match) begin
      pend_d = 1'b1;
    end

    if (acc_en) begin
      valid_d    = 1'b1;
      sel_mmio_d = is_mmio;
      if (is_mmio) begin
        mmio_rd_d = mmio_rd_val;
      end
    end

    ext_int_d = pend_q && tc_ie_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q    <= 32'd0;
      timecmp_q  <= 32'hFFFF_FFFF;
      tc_en_q    <= 1'b0;
      tc_ie_q    <= 1'b0;
      pend_q     <= 1'b0;
      ext_int_q  <= 1'b0;
      led_q      <= '0;
      valid_q    <= 1'b0;
      sel_mmio_q <= 1'b0;
      mmio_rd_q  <= 32'd0;
    end else begin
      timer_q    <= timer_d;
      timecmp_q  <= timecmp_d;
      tc_en_q    <= tc_en_d;
      tc_ie_q    <= tc_ie_d;
      pend_q     <= pend_d;
      ext_int_q  <= ext_int_d;
      led_q      <= led_d;
      valid_q    <= valid_d;
      sel_mmio_q <= sel_mmio_d;
      mmio_rd_q  <= mmio_rd_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.data_sram_rdata = !valid_q   ? 32'd0     :
                               sel_mmio_q ? mmio_rd_q : ram_rd_q;
  assign ext_int_o = ext_int_q;
  assign led_o     = led_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// ---------------------------------------------------------------------------
// tb_data_sram_resp
//   Directed bench for data_sram_resp. Inputs change on the falling edge,
//   outputs are sampled on the falling edge after the capturing rising edge.
// ---------------------------------------------------------------------------
module tb_data_sram_resp;

  localparam logic [31:0] A_TIMER = 32'hBFAF_0000;
  localparam logic [31:0] A_TCMP  = 32'hBFAF_0004;
  localparam logic [31:0] A_TCTRL = 32'hBFAF_0008;
  localparam logic [31:0] A_LED   = 32'hBFAF_000C;

  logic        clk;
  logic        rst_n;
  logic        ext_int;
  logic [15:0] led;
  logic [31:0] r;
  logic [31:0] r2;
  int          checks;
  int          errors;

  data_sram_if bus ();

  data_sram_resp #(
    .ADDR_W  (14),
    .MMIO_HI (16'hBFAF),
    .LED_W   (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .ext_int_o (ext_int),
    .led_o     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("check %s ok: %h", tag, got);
    end
  endtask

  // One bus cycle; returns rdata as seen the cycle after the access.
  task automatic access(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w, output logic [31:0] rd);
    @(negedge clk);
    bus.data_sram_en    = 1'b1;
    bus.data_sram_we    = w;
    bus.data_sram_addr  = a;
    bus.data_sram_wdata = d;
    @(negedge clk);
    bus.data_sram_en    = 1'b0;
    bus.data_sram_we    = 4'h0;
    rd = bus.data_sram_rdata;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_we    = 4'h0;
    bus.data_sram_addr  = 32'd0;
    bus.data_sram_wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_rdata", bus.data_sram_rdata, 32'd0);
    chk("rst_ext_int", {31'd0, ext_int}, 32'd0);
    chk("rst_led", {16'd0, led}, 32'd0);
    access(A_TCMP, 32'd0, 4'h0, r);
    chk("rst_timecmp", r, 32'hFFFF_FFFF);
    access(A_TCTRL, 32'd0, 4'h0, r);
    chk("rst_tctrl", r, 32'd0);

    // 1: full word write and read back
    access(32'h100, 32'hDEADBEEF, 4'hF, r);
    access(32'h100, 32'd0, 4'h0, r);
    chk("t1_read", r, 32'hDEADBEEF);
    // RAM aliases above the index bits
    access(32'h0001_0100, 32'd0, 4'h0, r);
    chk("t1_alias", r, 32'hDEADBEEF);

    // 2: byte-lane write, then en=0 holds rdata
    access(32'h300, 32'h11223344, 4'hF, r);
    access(32'h300, 32'h0000AB00, 4'b0010, r);
    access(32'h300, 32'd0, 4'h0, r);
    chk("t2_lane", r, 32'h1122AB44);
    repeat (3) @(negedge clk);
    chk("t2_hold", bus.data_sram_rdata, 32'h1122AB44);

    // 3: read-first on same-cycle read+write
    access(32'h200, 32'h1, 4'hF, r);
    access(32'h200, 32'h2, 4'hF, r);
    chk("t3_readfirst", r, 32'h1);
    access(32'h200, 32'd0, 4'h0, r);
    chk("t3_new", r, 32'h2);

    // 5: LED full write accepted, partial write ignored
    access(A_LED, 32'h0000A5A5, 4'hF, r);
    chk("t5_led", {16'd0, led}, 32'h0000A5A5);
    access(A_LED, 32'h0000FFFF, 4'b0011, r);
    chk("t5_led_partial", {16'd0, led}, 32'h0000A5A5);
    access(32'hBFAF_0FFC, 32'd0, 4'h0, r);
    chk("t5_led_read_alias", r, 32'h0000A5A5);
    access(A_TCMP, 32'h0000_0055, 4'b0111, r);
    access(A_TCMP, 32'd0, 4'h0, r);
    chk("t5_tcmp_partial", r, 32'hFFFF_FFFF);

    // 4: timer match, pending, interrupt, clear
    access(A_TCMP, 32'd10, 4'hF, r);
    access(A_TCTRL, 32'd3, 4'hF, r);
    // TIMER counts 0,1,...; match while TIMER==10 sets PEND at the 11th edge.
    repeat (11) @(negedge clk);
    chk("t4_int_not_yet", {31'd0, ext_int}, 32'd0);
    @(negedge clk);
    chk("t4_int_set", {31'd0, ext_int}, 32'd1);
    access(A_TCTRL, 32'd0, 4'h0, r);
    chk("t4_tctrl_pend", r, 32'd7);
    access(A_TCTRL, 32'd7, 4'hF, r);
    chk("t4_int_lag", {31'd0, ext_int}, 32'd1);
    @(negedge clk);
    chk("t4_int_clear", {31'd0, ext_int}, 32'd0);
    access(A_TCTRL, 32'd0, 4'h0, r);
    chk("t4_tctrl_after", r, 32'd3);
    access(A_TIMER, 32'd0, 4'h0, r);
    access(A_TIMER, 32'd0, 4'h0, r2);
    chk("t4_counting", r2 - r, 32'd2);
    access(A_TIMER, 32'd100, 4'hF, r);
    access(A_TIMER, 32'd0, 4'h0, r);
    chk("t4_timer_write_wins", r, 32'd101);

    // 6: reset mid-count with ext_int asserted
    access(A_TCMP, 32'd1000, 4'hF, r);
    for (int i = 0; i < 2000 && !ext_int; i++) @(negedge clk);
    chk("t6_int_rise", {31'd0, ext_int}, 32'd1);
    access(A_LED, 32'd0, 4'h0, r);
    chk("t6_pre_rdata", r, 32'h0000A5A5);
    @(negedge clk);
    bus.data_sram_en    = 1'b1;
    bus.data_sram_we    = 4'hF;
    bus.data_sram_addr  = 32'h100;
    bus.data_sram_wdata = 32'h12345678;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ext_int", {31'd0, ext_int}, 32'd0);
    chk("t6_rdata", bus.data_sram_rdata, 32'd0);
    chk("t6_led", {16'd0, led}, 32'd0);
    @(negedge clk);
    bus.data_sram_en = 1'b0;
    bus.data_sram_we = 4'h0;
    rst_n = 1'b1;
    access(A_TIMER, 32'd0, 4'h0, r);
    chk("t6_timer", r, 32'd0);
    access(32'h100, 32'd0, 4'h0, r);
    chk("t6_no_write", r, 32'hDEADBEEF);
    access(A_TCMP, 32'd0, 4'h0, r);
    chk("t6_timecmp", r, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
